otter_mtimer: RTL and testbench

Memory-mapped RISC-V machine timer (mtime/mtimecmp) on the OTTER I/O bus inside OTTER_Wrapper. It drives the `timer_int` line into the CSR/interrupt logic of the pipelined core. This replaces the bench-tied-low `timer_int` with real interrupt generation. Software programs the compare value, prescaler and enable through bus stores and reads time through bus loads.

---
 rtl/otter_mtimer.sv | 99 +++++++++
 tb/tb_otter_mtimer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/otter_mtimer.sv
// Memory-mapped RISC-V machine timer (mtime/mtimecmp) on the OTTER I/O bus.
// Drives a registered level timer_int whenever mtime >= mtimecmp.
module otter_mtimer #(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
  parameter logic [15:0] PRESCALE_RST = 16'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic        IOBUS_SEL,
  output logic [31:0] IOBUS_RD,
  output logic        timer_int
);

  localparam logic [5:0] W_MTIME_LO = 6'h00;
  localparam logic [5:0] W_MTIME_HI = 6'h01;
  localparam logic [5:0] W_CMP_LO   = 6'h02;
  localparam logic [5:0] W_CMP_HI   = 6'h03;
  localparam logic [5:0] W_CTRL     = 6'h04;
  localparam logic [5:0] W_PRE      = 6'h05;

  logic [63:0] mtime, mtimecmp, mtime_inc;
  logic [15:0] prescale, pc;
  logic        en;
  logic [5:0]  word;
  logic        wr, wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl, wr_pre;
  logic        pc_hit, tick;
  logic [31:0] rd_mux;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^{IOBUS_ADDR[1:0], BASE_ADDR[7:0]};

  assign IOBUS_SEL = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
  assign word      = IOBUS_ADDR[7:2];
  assign wr        = IOBUS_WR && IOBUS_SEL;
  assign wr_mlo    = wr && (word == W_MTIME_LO);
  assign wr_mhi    = wr && (word == W_MTIME_HI);
  assign wr_clo    = wr && (word == W_CMP_LO);
  assign wr_chi    = wr && (word == W_CMP_HI);
  assign wr_ctrl   = wr && (word == W_CTRL);
  assign wr_pre    = wr && (word == W_PRE);

  // Reprogramming CTRL/PRESCALE restarts the prescale period, so no tick that cycle.
  assign pc_hit    = (pc == prescale);
  assign tick      = en && pc_hit && !(wr_ctrl || wr_pre);
  assign mtime_inc = mtime + 64'd1;

  always_comb begin
    rd_mux = 32'd0;
    if (IOBUS_SEL) begin
      case (word)
        W_MTIME_LO: rd_mux = mtime[31:0];
        W_MTIME_HI: rd_mux = mtime[63:32];
        W_CMP_LO:   rd_mux = mtimecmp[31:0];
        W_CMP_HI:   rd_mux = mtimecmp[63:32];
        W_CTRL:     rd_mux = {31'd0, en};
        W_PRE:      rd_mux = {16'd0, prescale};
        default:    rd_mux = 32'd0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mtime     <= 64'd0;
      mtimecmp  <= '1;
      en        <= 1'b0;
      prescale  <= PRESCALE_RST;
      pc        <= 16'd0;
      IOBUS_RD  <= 32'd0;
      timer_int <= 1'b0;
    end else begin
      if (wr_ctrl || wr_pre)
        pc <= 16'd0;
      else if (en)
        pc <= pc_hit ? 16'd0 : pc + 16'd1;

      if (wr_ctrl) en       <= IOBUS_OUT[0];
      if (wr_pre)  prescale <= IOBUS_OUT[15:0];

      // A software write to either half wins over the increment.
      if (wr_mlo)
        mtime[31:0] <= IOBUS_OUT;
      else if (wr_mhi)
        mtime[63:32] <= IOBUS_OUT;
      else if (tick)
        mtime <= mtime_inc;

      if (wr_clo) mtimecmp[31:0]  <= IOBUS_OUT;
      if (wr_chi) mtimecmp[63:32] <= IOBUS_OUT;

      IOBUS_RD  <= rd_mux;
      timer_int <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_otter_mtimer.sv
// Directed bench for otter_mtimer: reset read table plus timing sequences
// for prescaling, carry/wrap, interrupt latency, write-vs-tick and reset.
module tb_otter_mtimer;

  localparam logic [31:0] BASE = 32'h1100_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        wr = 1'b0;
  logic        sel;
  logic [31:0] rd;
  logic        tint;

  int checks = 0;
  int errors = 0;

  otter_mtimer #(.BASE_ADDR(BASE), .PRESCALE_RST(16'd0)) dut (
    .CLK(clk), .RST(rst), .IOBUS_ADDR(addr), .IOBUS_OUT(wdata),
    .IOBUS_WR(wr), .IOBUS_SEL(sel), .IOBUS_RD(rd), .timer_int(tint)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_rd;
    logic        exp_sel;
  } rd_vec_t;

  rd_vec_t vec [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end at a negedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
    addr = a; wr = 1'b0;
    #1 s = sel;
    @(negedge clk);
    d = rd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_reset_table(input string tag);
    logic [31:0] d;
    logic        s;
    for (int i = 0; i < 9; i++) begin
      bus_read(vec[i].addr, d, s);
      check($sformatf("%s rd[%0d]", tag, i), {32'd0, d}, {32'd0, vec[i].exp_rd});
      check($sformatf("%s sel[%0d]", tag, i), {63'd0, s}, {63'd0, vec[i].exp_sel});
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        s;

    vec[0] = '{BASE + 32'h00, 32'h0000_0000, 1'b1};
    vec[1] = '{BASE + 32'h04, 32'h0000_0000, 1'b1};
    vec[2] = '{BASE + 32'h08, 32'hFFFF_FFFF, 1'b1};
    vec[3] = '{32'h1100_0208,  32'h0000_0000, 1'b0};
    vec[4] = '{BASE + 32'h0C, 32'hFFFF_FFFF, 1'b1};
    vec[5] = '{BASE + 32'h10, 32'h0000_0000, 1'b1};
    vec[6] = '{BASE + 32'h14, 32'h0000_0000, 1'b1};
    vec[7] = '{BASE + 32'h18, 32'h0000_0000, 1'b1};
    vec[8] = '{BASE + 32'hFC, 32'h0000_0000, 1'b1};

    // 1: reset state and address decode
    @(negedge clk);
    do_reset();
    check("reset timer_int", {63'd0, tint}, 64'd0);
    run_reset_table("reset");
    bus_write(32'h1100_0208, 32'h0);
    bus_write(BASE + 32'h18, 32'h1234);
    bus_read(BASE + 32'h08, d, s);
    check("foreign write ignored", {32'd0, d}, 64'hFFFF_FFFF);
    bus_read(BASE + 32'h18, d, s);
    check("unmapped write ignored", {32'd0, d}, 64'd0);

    // 2: enable with prescale 0, then freeze
    do_reset();
    bus_write(BASE + 32'h10, 32'h1);
    repeat (10) @(negedge clk);
    bus_read(BASE + 32'h00, d, s);
    check("ps0 count", {32'd0, d}, 64'd10);
    bus_write(BASE + 32'h10, 32'h0);
    repeat (20) @(negedge clk);
    bus_read(BASE + 32'h00, d, s);
    check("frozen count", {32'd0, d}, 64'd11);
    bus_read(BASE + 32'h10, d, s);
    check("ctrl readback", {32'd0, d}, 64'd0);

    // 3: prescale 3 -> one tick per 4 clocks
    do_reset();
    bus_write(BASE + 32'h14, 32'hABCD_0003);
    bus_write(BASE + 32'h10, 32'h1);
    repeat (40) @(negedge clk);
    bus_read(BASE + 32'h00, d, s);
    check("ps3 count", {32'd0, d}, 64'd10);
    bus_read(BASE + 32'h14, d, s);
    check("prescale readback", {32'd0, d}, 64'd3);

    // 4: carry into HI and 64-bit wrap
    do_reset();
    bus_write(BASE + 32'h00, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h04, 32'h0);
    bus_write(BASE + 32'h10, 32'h1);
    repeat (2) @(negedge clk);
    bus_write(BASE + 32'h10, 32'h0);
    bus_read(BASE + 32'h04, d, s);
    check("carry HI", {32'd0, d}, 64'd1);
    bus_read(BASE + 32'h00, d, s);
    check("carry LO", {32'd0, d}, 64'd0);
    bus_write(BASE + 32'h00, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h10, 32'h1);
    @(negedge clk);
    bus_write(BASE + 32'h10, 32'h0);
    bus_read(BASE + 32'h00, d, s);
    check("wrap LO", {32'd0, d}, 64'd0);
    bus_read(BASE + 32'h04, d, s);
    check("wrap HI", {32'd0, d}, 64'd0);

    // 5: interrupt rise latency and acknowledge by raising mtimecmp
    do_reset();
    bus_write(BASE + 32'h08, 32'd100);
    bus_write(BASE + 32'h0C, 32'd0);
    bus_write(BASE + 32'h00, 32'd95);
    bus_write(BASE + 32'h10, 32'h1);
    // ticks at the next edges: 96..100 reached after 5 edges, int one edge later
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("int edge %0d", k), {63'd0, tint}, {63'd0, (k >= 6)});
    end
    bus_write(BASE + 32'h08, 32'd1000);
    check("int after cmp write", {63'd0, tint}, 64'd1);
    @(negedge clk);
    check("int dropped", {63'd0, tint}, 64'd0);

    // 6: write LO in a tick cycle wins, next tick continues from it
    do_reset();
    bus_write(BASE + 32'h04, 32'd7);
    bus_write(BASE + 32'h10, 32'h1);
    repeat (3) @(negedge clk);
    bus_write(BASE + 32'h00, 32'd5);
    bus_read(BASE + 32'h00, d, s);
    check("write beats tick", {32'd0, d}, 64'd5);
    bus_read(BASE + 32'h00, d, s);
    check("tick after write", {32'd0, d}, 64'd6);
    bus_read(BASE + 32'h04, d, s);
    check("HI held", {32'd0, d}, 64'd7);

    // mid-count reset with interrupt asserted
    bus_write(BASE + 32'h0C, 32'd0);
    bus_write(BASE + 32'h08, 32'd0);
    @(negedge clk);
    check("int before reset", {63'd0, tint}, 64'd1);
    addr = BASE + 32'h08;
    do_reset();
    check("int after reset", {63'd0, tint}, 64'd0);
    check("rd after reset", {32'd0, rd}, 64'd0);
    run_reset_table("post");
    check("int stays low", {63'd0, tint}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
